serializer: RTL

- Parallel-to-serial converter; the transmit end of the team's serial link, paired with the existing deserializer on the receive side.
- Accepts one parallel word plus a valid-bit count and shifts it out one bit per clock, MSB first.
- Frames are qualified by a serial valid strobe.
- Asserts busy while a word is in flight; upstream logic must hold off new words during that time.

---
 rtl/serializer.sv | 42 ++++
 1 files changed

// File: rtl/serializer.sv
// serializer: MSB-first parallel-to-serial transmitter with per-word valid-bit count and serial valid strobe
module serializer #(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [DATA_BUS_WIDTH-1:0] data_i,
  input  logic [DATA_MOD_WIDTH-1:0] data_mod_i,
  input  logic                      data_val_i,
  output logic                      ser_data_o,
  output logic                      ser_data_val_o,
  output logic                      busy_o
);
  typedef enum logic {IDLE_S, SEND_S} state_t;
  state_t state, state_d;
  logic [DATA_MOD_WIDTH-1:0] cnt, cnt_d, len_m1;
  logic [DATA_BUS_WIDTH-1:0] sr, sr_d;
  logic acc, shift;
  assign busy_o = state == SEND_S && cnt != '0;
  assign shift = busy_o;
  assign acc = data_val_i && !busy_o && data_mod_i != DATA_MOD_WIDTH'(1) && data_mod_i != DATA_MOD_WIDTH'(2);
  assign len_m1 = data_mod_i == '0 ? DATA_MOD_WIDTH'(DATA_BUS_WIDTH - 1) : data_mod_i - 1'b1;
  assign ser_data_o = sr[DATA_BUS_WIDTH-1];
  assign ser_data_val_o = state == SEND_S;
  always_comb begin
    state_d = acc ? SEND_S : shift ? SEND_S : IDLE_S;
    cnt_d = acc ? len_m1 : shift ? cnt - 1'b1 : '0;
    sr_d = acc ? data_i : shift ? sr << 1 : '0;
  end
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state <= IDLE_S;
      cnt <= '0;
      sr <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      sr <= sr_d;
    end
  end
endmodule
